fifo_frame_packer: RTL and testbench

FIFO_FRAME_PACKER -- requirements
Module: fifo_frame_packer

---
 rtl/fifo_frame_packer_pkg.sv | 20 ++
 rtl/fifo_frame_packer_csum.sv | 36 +++
 rtl/fifo_frame_packer.sv | 168 ++++++++++++++++
 tb/tb_fifo_frame_packer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_frame_packer_pkg.sv
// fifo_frame_packer_pkg
// Shared definitions for the FIFO frame packer: the packer state encoding,
// the default frame start marker and the fixed per-frame byte overhead
// (sync byte, sequence byte, checksum byte).
package fifo_frame_packer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_SEQ,
    ST_RD,
    ST_CAP,
    ST_DATA,
    ST_CSUM
  } packer_state_e;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  localparam int         FRAME_OVERHEAD    = 3;

endpackage

// File: rtl/fifo_frame_packer_csum.sv
// frame_xor_csum
// 8-bit XOR checksum accumulator for one frame.
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-low reset
//   load_i     - load the accumulator with load_val_i (start of frame)
//   load_val_i - seed value, the frame sequence number
//   acc_en_i   - XOR data_i into the accumulator
//   data_i     - payload byte to accumulate
//   csum_o     - current checksum value
module frame_xor_csum (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       acc_en_i,
  input  logic [7:0] data_i,
  output logic [7:0] csum_o
);

  logic [7:0] csum_q;

  // Load wins over accumulate so a new frame always starts from its seed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      csum_q <= 8'h00;
    end else if (load_i) begin
      csum_q <= load_val_i;
    end else if (acc_en_i) begin
      csum_q <= csum_q ^ data_i;
    end
  end

  assign csum_o = csum_q;

endmodule

// File: rtl/fifo_frame_packer.sv
// fifo_frame_packer
// Pulls FRAME_LEN payload bytes from an upstream FIFO and emits them as a
// framed byte stream: SYNC_BYTE, SEQ, payload..., CSUM (XOR of SEQ and the
// payload). A frame is only started once the FIFO holds a full payload.
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-low reset
//   fifo_rd    - one-cycle read strobe to the FIFO
//   fifo_data  - FIFO read data, valid the cycle after fifo_rd
//   fifo_empty - FIFO empty flag
//   fifo_cnt   - FIFO occupancy
//   tx_data    - outgoing frame byte
//   tx_valid   - tx_data valid
//   tx_ready   - downstream accepts when tx_valid and tx_ready are both high
//   tx_last    - marks the checksum byte
//   frame_cnt  - completed frame count, wraps
//   busy       - high whenever the packer is not idle
module fifo_frame_packer
  import fifo_frame_packer_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 32,
  parameter logic [7:0]  SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
  input  logic        clk,
  input  logic        rst,
  output logic        fifo_rd,
  input  logic [7:0]  fifo_data,
  input  logic        fifo_empty,
  input  logic [15:0] fifo_cnt,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  localparam logic [15:0] FRAME_LEN_W = 16'(FRAME_LEN);
  localparam logic [7:0]  LAST_IDX    = 8'(FRAME_LEN - 1);

  packer_state_e state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    seq_q, seq_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          tx_last_q, tx_last_d;
  logic          csum_load, csum_acc;
  logic [7:0]    csum_val;
  logic          hs;

  assign hs = tx_valid_q & tx_ready;

  frame_xor_csum u_csum (
    .clk        (clk),
    .rst        (rst),
    .load_i     (csum_load),
    .load_val_i (seq_q),
    .acc_en_i   (csum_acc),
    .data_i     (fifo_data),
    .csum_o     (csum_val)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'h00;
      seq_q       <= 8'h00;
      frame_cnt_q <= 16'h0000;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      tx_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      seq_q       <= seq_d;
      frame_cnt_q <= frame_cnt_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      tx_last_q   <= tx_last_d;
    end
  end

  // tx_data/tx_valid are registered and only change on a handshake or when
  // a fresh byte is loaded, which keeps the output stable while stalled.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    seq_d       = seq_q;
    frame_cnt_d = frame_cnt_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    tx_last_d   = tx_last_q;
    csum_load   = 1'b0;
    csum_acc    = 1'b0;
    fifo_rd     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if ((fifo_cnt >= FRAME_LEN_W) && !fifo_empty) begin
          state_d    = ST_SYNC;
          cnt_d      = 8'h00;
          csum_load  = 1'b1;
          tx_data_d  = SYNC_BYTE;
          tx_valid_d = 1'b1;
        end
      end
      ST_SYNC: begin
        if (hs) begin
          state_d   = ST_SEQ;
          tx_data_d = seq_q;
        end
      end
      ST_SEQ: begin
        if (hs) begin
          state_d    = ST_RD;
          tx_valid_d = 1'b0;
        end
      end
      ST_RD: begin
        // Gated by rst so no strobe reaches the FIFO while reset is held.
        if (!fifo_empty && rst) begin
          fifo_rd = 1'b1;
          state_d = ST_CAP;
        end
      end
      ST_CAP: begin
        state_d    = ST_DATA;
        tx_data_d  = fifo_data;
        tx_valid_d = 1'b1;
        csum_acc   = 1'b1;
      end
      ST_DATA: begin
        if (hs) begin
          if (cnt_q == LAST_IDX) begin
            // Checksum already includes this byte, accumulated in CAP.
            state_d   = ST_CSUM;
            tx_data_d = csum_val;
            tx_last_d = 1'b1;
          end else begin
            state_d    = ST_RD;
            cnt_d      = cnt_q + 8'd1;
            tx_valid_d = 1'b0;
          end
        end
      end
      ST_CSUM: begin
        if (hs) begin
          state_d     = ST_IDLE;
          tx_valid_d  = 1'b0;
          tx_last_d   = 1'b0;
          seq_d       = seq_q + 8'd1;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign tx_last   = tx_last_q;
  assign frame_cnt = frame_cnt_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fifo_frame_packer.sv
// tb_fifo_frame_packer
// Self-checking bench: a queue-based FIFO model feeds the packer, a monitor
// records every accepted byte, and a frame-level reference model predicts
// each frame from the bytes written to the FIFO.
module tb_fifo_frame_packer;

  localparam int         FL   = 4;
  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_rd;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_empty;
  logic [15:0] fifo_cnt;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_last;
  logic [15:0] frame_cnt;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] fifoQ[$];
  logic [7:0] refQ[$];
  logic [7:0] expQ[$];
  logic [7:0] capData[$];
  logic       capLast[$];

  int         rdStrobes = 0;
  int         stableErrors = 0;
  int         lastSeen = 0;
  logic       heldValid = 1'b0;
  logic [7:0] heldData = 8'h00;
  logic       toggleMode = 1'b0;
  logic       forceEmpty = 1'b0;
  logic [7:0] seqModel = 8'h00;
  logic [15:0] frameModel = 16'h0000;

  fifo_frame_packer #(.FRAME_LEN(FL), .SYNC_BYTE(SYNC)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_rd    (fifo_rd),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_cnt   (fifo_cnt),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_last    (tx_last),
    .frame_cnt  (frame_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Upstream FIFO: data appears the cycle after a read strobe
  always @(posedge clk) begin
    if (fifo_rd && fifoQ.size() > 0) fifo_data <= fifoQ.pop_front();
  end

  // Monitor: records handshakes, read strobes and stall stability
  always @(negedge clk) begin
    if (rst) begin
      if (tx_valid && tx_ready) begin
        capData.push_back(tx_data);
        capLast.push_back(tx_last);
        if (tx_last) lastSeen++;
      end
      if (fifo_rd) rdStrobes++;
      if (heldValid && (!tx_valid || tx_data !== heldData)) stableErrors++;
    end
    heldValid = rst && tx_valid && !tx_ready;
    heldData  = tx_data;
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
    if (toggleMode) tx_ready = ~tx_ready;
    fifo_cnt   = 16'(fifoQ.size());
    fifo_empty = forceEmpty || (fifoQ.size() == 0);
  endtask

  task automatic pushByte(input logic [7:0] b);
    fifoQ.push_back(b);
    refQ.push_back(b);
    fifo_cnt   = 16'(fifoQ.size());
    fifo_empty = forceEmpty || (fifoQ.size() == 0);
  endtask

  // Reference model: one frame from the next FL bytes written to the FIFO
  task automatic buildExpected();
    logic [7:0] x;
    logic [7:0] b;
    expQ.delete();
    expQ.push_back(SYNC);
    expQ.push_back(seqModel);
    x = seqModel;
    for (int i = 0; i < FL; i++) begin
      b = refQ.pop_front();
      expQ.push_back(b);
      x = x ^ b;
    end
    expQ.push_back(x);
    seqModel   = seqModel + 8'd1;
    frameModel = frameModel + 16'd1;
  endtask

  task automatic runFrame(input string name);
    int start;
    int n;
    start = lastSeen;
    n = 0;
    while (lastSeen == start && n < 400) begin
      stepCycle();
      n++;
    end
    vectors++;
    if (lastSeen == start) begin
      miscompares++;
      $display("[TB] FAIL %s_timeout got=no tx_last exp=frame end within 400 cycles", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tx_ready = 1'b1;
    fifo_cnt = 16'd0;
    fifo_empty = 1'b1;
    repeat (3) stepCycle();
    vectors++;
    if ({tx_valid, tx_last, busy, fifo_rd} !== 4'b0000 || tx_data !== 8'h00 || frame_cnt !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL reset got=v%b l%b b%b rd%b d%h fc%0d exp=all zero",
               tx_valid, tx_last, busy, fifo_rd, tx_data, frame_cnt);
    end
    rst = 1'b1;
    stepCycle();
  endtask

  task automatic test_basic_frame();
    int rd0;
    capData.delete(); capLast.delete();
    rd0 = rdStrobes;
    for (int i = 1; i <= FL; i++) pushByte(8'(i));
    runFrame("basic");
    buildExpected();
    vectors++;
    if (capData.size() !== FL + 3) begin
      miscompares++;
      $display("[TB] FAIL basic_len got=%0d exp=%0d", capData.size(), FL + 3);
    end else begin
      for (int i = 0; i < FL + 3; i++) begin
        vectors++;
        if (capData[i] !== expQ[i] || capLast[i] !== (i == FL + 2)) begin
          miscompares++;
          $display("[TB] FAIL basic_byte%0d got=%h/last%b exp=%h/last%b", i, capData[i], capLast[i], expQ[i], i == FL + 2);
        end
      end
    end
    vectors++;
    if (frame_cnt !== frameModel || rdStrobes - rd0 !== FL) begin
      miscompares++;
      $display("[TB] FAIL basic_counts got=fc%0d rd%0d exp=fc%0d rd%0d", frame_cnt, rdStrobes - rd0, frameModel, FL);
    end
  endtask

  task automatic test_ready_toggle();
    capData.delete(); capLast.delete();
    stableErrors = 0;
    for (int i = 0; i < FL; i++) pushByte(8'($urandom));
    toggleMode = 1'b1;
    runFrame("toggle");
    toggleMode = 1'b0;
    tx_ready = 1'b1;
    buildExpected();
    vectors++;
    if (capData.size() !== FL + 3) begin
      miscompares++;
      $display("[TB] FAIL toggle_len got=%0d exp=%0d", capData.size(), FL + 3);
    end else begin
      for (int i = 0; i < FL + 3; i++) begin
        vectors++;
        if (capData[i] !== expQ[i] || capLast[i] !== (i == FL + 2)) begin
          miscompares++;
          $display("[TB] FAIL toggle_byte%0d got=%h exp=%h", i, capData[i], expQ[i]);
        end
      end
    end
    vectors++;
    if (stableErrors !== 0) begin
      miscompares++;
      $display("[TB] FAIL toggle_stable got=%0d changes exp=0", stableErrors);
    end
  endtask

  task automatic test_threshold();
    int rd0;
    int busyHits;
    capData.delete(); capLast.delete();
    rd0 = rdStrobes;
    busyHits = 0;
    for (int i = 0; i < FL - 1; i++) pushByte(8'($urandom));
    repeat (8) begin
      stepCycle();
      if (busy !== 1'b0) busyHits++;
    end
    vectors++;
    if (busyHits !== 0 || rdStrobes !== rd0) begin
      miscompares++;
      $display("[TB] FAIL threshold_idle got=busy%0d rd%0d exp=0 0", busyHits, rdStrobes - rd0);
    end
    pushByte(8'($urandom));
    stepCycle();
    vectors++;
    if (busy !== 1'b1 || tx_valid !== 1'b1 || tx_data !== SYNC) begin
      miscompares++;
      $display("[TB] FAIL threshold_start got=b%b v%b d%h exp=b1 v1 d%h", busy, tx_valid, tx_data, SYNC);
    end
    runFrame("threshold");
    buildExpected();
    vectors++;
    if (capData.size() !== FL + 3 || capData[FL + 2] !== expQ[FL + 2]) begin
      miscompares++;
      $display("[TB] FAIL threshold_frame got=len%0d exp=len%0d csum %h", capData.size(), FL + 3, expQ[FL + 2]);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2 * FL; i++) pushByte(8'($urandom));
    for (int f = 0; f < 2; f++) begin
      capData.delete(); capLast.delete();
      runFrame("b2b");
      buildExpected();
      vectors++;
      if (busy !== 1'b0 || tx_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL b2b_gap%0d got=b%b v%b exp=b0 v0", f, busy, tx_valid);
      end
      vectors++;
      if (capData.size() !== FL + 3) begin
        miscompares++;
        $display("[TB] FAIL b2b_len%0d got=%0d exp=%0d", f, capData.size(), FL + 3);
      end else begin
        for (int i = 0; i < FL + 3; i++) begin
          if (capData[i] !== expQ[i]) begin
            miscompares++;
            $display("[TB] FAIL b2b_byte%0d_%0d got=%h exp=%h", f, i, capData[i], expQ[i]);
          end
        end
      end
    end
  endtask

  task automatic test_empty_stall();
    int rd0;
    int n;
    capData.delete(); capLast.delete();
    for (int i = 0; i < FL; i++) pushByte(8'($urandom));
    n = 0;
    while (capData.size() < 1 && n < 50) begin
      stepCycle();
      n++;
    end
    forceEmpty = 1'b1;
    fifo_empty = 1'b1;
    rd0 = rdStrobes;
    repeat (6) stepCycle();
    vectors++;
    if (rdStrobes !== rd0 || busy !== 1'b1 || capData.size() !== 2) begin
      miscompares++;
      $display("[TB] FAIL stall_hold got=rd%0d b%b n%0d exp=rd0 b1 n2", rdStrobes - rd0, busy, capData.size());
    end
    forceEmpty = 1'b0;
    fifo_empty = (fifoQ.size() == 0);
    runFrame("stall");
    buildExpected();
    vectors++;
    if (rdStrobes - rd0 !== FL) begin
      miscompares++;
      $display("[TB] FAIL stall_reads got=%0d exp=%0d", rdStrobes - rd0, FL);
    end
    vectors++;
    if (capData.size() !== FL + 3) begin
      miscompares++;
      $display("[TB] FAIL stall_len got=%0d exp=%0d", capData.size(), FL + 3);
    end else begin
      for (int i = 0; i < FL + 3; i++) begin
        if (capData[i] !== expQ[i]) begin
          miscompares++;
          $display("[TB] FAIL stall_byte%0d got=%h exp=%h", i, capData[i], expQ[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [7:0] dropped;
    capData.delete(); capLast.delete();
    for (int i = 0; i < FL; i++) pushByte(8'($urandom));
    n = 0;
    while (capData.size() < 3 && n < 50) begin
      stepCycle();
      n++;
    end
    tx_ready = 1'b0;
    n = 0;
    while (tx_valid !== 1'b1 && n < 20) begin
      stepCycle();
      n++;
    end
    rst = 1'b0;
    stepCycle();
    vectors++;
    if ({tx_valid, tx_last, busy, fifo_rd} !== 4'b0000 || tx_data !== 8'h00 || frame_cnt !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL midreset got=v%b l%b b%b rd%b d%h fc%0d exp=all zero",
               tx_valid, tx_last, busy, fifo_rd, tx_data, frame_cnt);
    end
    rst = 1'b1;
    tx_ready = 1'b1;
    for (int i = 0; i < 2; i++) dropped = refQ.pop_front();
    seqModel = 8'h00;
    frameModel = 16'h0000;
    capData.delete(); capLast.delete();
    for (int i = 0; i < FL; i++) pushByte(8'($urandom));
    runFrame("midreset");
    buildExpected();
    vectors++;
    if (capData.size() !== FL + 3 || capData[0] !== 8'hA5 || capData[1] !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL midreset_head got=len%0d %h %h exp=len%0d a5 00", capData.size(), capData[0], capData[1], FL + 3);
    end else begin
      for (int i = 0; i < FL + 3; i++) begin
        vectors++;
        if (capData[i] !== expQ[i]) begin
          miscompares++;
          $display("[TB] FAIL midreset_byte%0d got=%h exp=%h", i, capData[i], expQ[i]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int bad;
    rst = 1'b0;
    stepCycle();
    rst = 1'b1;
    seqModel = 8'h00;
    frameModel = 16'h0000;
    for (int f = 0; f < 257; f++) begin
      capData.delete(); capLast.delete();
      for (int i = 0; i < FL; i++) pushByte(8'($urandom));
      runFrame("wrap");
      buildExpected();
      bad = (capData.size() !== FL + 3) ? 1 : 0;
      for (int i = 0; i < capData.size() && i < FL + 3; i++) if (capData[i] !== expQ[i]) bad = 1;
      vectors++;
      if (bad != 0) begin
        miscompares++;
        $display("[TB] FAIL wrap_frame%0d got=seq %h exp=seq %h", f, capData.size() > 1 ? capData[1] : 8'hxx, expQ[1]);
      end
      if (f == 255) begin
        vectors++;
        if (frame_cnt !== 16'd256) begin
          miscompares++;
          $display("[TB] FAIL wrap_count got=%0d exp=256", frame_cnt);
        end
      end
    end
    vectors++;
    if (capData.size() < 2 || capData[1] !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL wrap_seq257 got=%h exp=00", capData.size() > 1 ? capData[1] : 8'hxx);
    end
  endtask

  initial begin
    tx_ready = 1'b1;
    rst = 1'b0;
    fifo_cnt = 16'd0;
    fifo_empty = 1'b1;
    test_reset();
    test_basic_frame();
    test_ready_toggle();
    test_threshold();
    test_back_to_back();
    test_empty_stall();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
